alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Multi-cycle command front-end that drives the 32-bit combinational ALU. It accepts operation commands over a valid/ready handshake and reads operands from an internal 8-entry register file. It presents the operands to the ALU, holds them for a programmable settle time, then captures the ALU result and flags. It writes the result back and returns it to the requester over a second valid/ready handshake.

## Interface

**Parameters**
- `WIDTH`, default 32: datapath and register width.
- `ALU_LAT`, default 1, legal range 1–15: number of cycles ALU inputs are held stable before the result is sampled.

**Ports** (clock and reset first)
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: sequencer can accept a command.
- `cmd_sel`, in, 4: ALU op. Encodings:
  - 0000 AND, 0001 OR, 0010 NOT(A), 0011 NOR, 0100 XOR, 0101 NAND, 0110 ADD, 0111 SUB.
  - 1xxx is reserved and is treated as AND.
- `cmd_wr_imm`, in, 1: write `cmd_imm` to `rd`; no ALU op.
- `cmd_use_carry`, in, 1: drive `alu_cin` from the stored C flag; otherwise 0.
- `cmd_rd`, `cmd_rs1`, `cmd_rs2`, in, 3 each: destination and source register indices.
- `cmd_imm`, in, WIDTH: immediate value.
- `alu_a`, `alu_b`, out, WIDTH: ALU operands, registered.
- `alu_sel`, out, 4: registered copy of `cmd_sel`.
- `alu_cin`, out, 1: registered carry-in.
- `alu_y`, in, WIDTH: ALU result.
- `alu_cout`, `alu_neg`, `alu_zero`, `alu_ovf`, in, 1 each: ALU flags.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: requester accepts the response.
- `rsp_data`, out, WIDTH: value written to `rd`.
- `rsp_flags`, out, 4: {C,N,Z,V} after the command.

## Operation

- **Register file**
  - r0..r7, each WIDTH bits.
  - r0 always reads 0; writes to r0 are discarded, but `rsp_data` still returns the computed value.
- **Flag register** {C,N,Z,V}
  - Updated only by ALU commands.
  - Immediate writes leave the flags unchanged.
- **FSM states:** IDLE, ISSUE, RESP.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`:
    - If `cmd_wr_imm`=1: write `cmd_imm` to `rd`, load `rsp_data`=`cmd_imm`, go to RESP.
    - Otherwise:
      - Latch `alu_a`=R[rs1], `alu_b`=R[rs2], `alu_sel`=`cmd_sel`, `alu_cin`=`cmd_use_carry`&C.
      - Latch `rd`.
      - Load the settle counter with ALU_LAT-1 and go to ISSUE.
- **ISSUE**
  - `cmd_ready`=0; ALU inputs held constant.
  - The counter decrements each cycle.
  - On the cycle the counter equals 0:
    - Sample `alu_y` and the flags.
    - Write `alu_y` to R[rd] and {`alu_cout`,`alu_neg`,`alu_zero`,`alu_ovf`} to the flag register.
    - Load `rsp_data` and `rsp_flags`, go to RESP.
- **RESP**
  - `rsp_valid`=1, `cmd_ready`=0.
  - `rsp_data` and `rsp_flags` stay stable until `rsp_valid`&&`rsp_ready`; on that handshake go to IDLE.
- **Read-before-write:** source operands are read at the accept edge, so `rs`==`rd` uses the old value.
- **ALU outputs in IDLE/RESP:** `alu_*` outputs hold their last values.
- **Overlap:** commands do not overlap. `cmd_valid` outside IDLE is ignored and is not queued.

## Timing

- **Reset values:**
  - `cmd_ready`=1, `rsp_valid`=0.
  - `rsp_data`=0, `rsp_flags`=0.
  - `alu_a`=`alu_b`=0, `alu_sel`=0, `alu_cin`=0.
  - All registers 0, flags 0, state IDLE.
- **Reset priority:**
  - `rst_n` low at any edge overrides all other activity, including mid-ISSUE and mid-RESP.
  - No write-back occurs for an aborted command.
- **ALU command latency:**
  - Accept at edge T.
  - Sample and write-back at edge T+ALU_LAT.
  - `rsp_valid` high in the cycle after edge T+ALU_LAT.
- **Immediate command latency:** `rsp_valid` high in the cycle after the accept edge.
- **Throughput:** with `rsp_ready` held at 1, at most one ALU command per ALU_LAT+2 cycles and one immediate per 2 cycles.
- **Back-to-back write/read:** a register written by command N is visible to command N+1, because write-back precedes re-entry to IDLE.
- **Arithmetic:** all arithmetic is performed by the ALU. No width extension; results are WIDTH bits and any carry appears only as C.

## Test plan

1. **Reset:** hold `rst_n`=0 for 2 cycles, then release.
   - Required: `cmd_ready`=1, `rsp_valid`=0, all `alu_*` outputs=0, `rsp_flags`=0.
   - Then OR r1,r2 returns 0 with Z=1.
2. **Immediate write then AND:** write imm r1=0x0000_00FF and r2=0x0000_0F0F, then AND r3,r1,r2 with ALU_LAT=1.
   - Required: `rsp_data`=0x0000_000F, flags=0000.
   - `rsp_valid` is asserted 2 cycles after the accept edge.
3. **ADD overflow:** r1=0x7FFF_FFFF, r2=1, ADD r4.
   - Required: 0x8000_0000, {C,N,Z,V}=0101.
4. **Carry chain:** ADD 0xFFFF_FFFF+1 gives 0, C=1, Z=1.
   - A following ADD with `cmd_use_carry`=1 of 0+0 drives `alu_cin`=1 and returns 1.
5. **Backpressure:** hold `rsp_ready`=0 for 5 cycles while pulsing `cmd_valid`.
   - Required: `rsp_data` stable, `cmd_ready`=0, no extra command accepted, register file unchanged.
6. **r0 and reset abort:**
   - Write imm 0x1234 to r0; `rsp_data`=0x1234, but a later read of r0 returns 0.
   - Assert `rst_n`=0 in the ISSUE cycle of ADD r5; afterwards r5 reads 0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Multi-cycle command front-end for a combinational ALU: 8-entry register
// file, operand issue with programmable settle time, write-back and response.
module alu_cmd_sequencer #(
   parameter int WIDTH   = 32,
   parameter int ALU_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_sel,
   input  logic             cmd_wr_imm,
   input  logic             cmd_use_carry,
   input  logic [2:0]       cmd_rd,
   input  logic [2:0]       cmd_rs1,
   input  logic [2:0]       cmd_rs2,
   input  logic [WIDTH-1:0] cmd_imm,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_sel,
   output logic             alu_cin,
   input  logic [WIDTH-1:0] alu_y,
   input  logic             alu_cout,
   input  logic             alu_neg,
   input  logic             alu_zero,
   input  logic             alu_ovf,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [3:0]       rsp_flags
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

   state_t           state;
   state_t           state_nxt;
   logic [3:0]       cnt;
   logic [2:0]       rd_q;
   logic [3:0]       flags;
   logic [WIDTH-1:0] rf [8];
   logic [WIDTH-1:0] rs1_val;
   logic [WIDTH-1:0] rs2_val;
   logic             accept;
   logic             done;
   logic             wr_en;
   logic [2:0]       wr_idx;
   logic [WIDTH-1:0] wr_data;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            accept    = cmd_valid;
            if (cmd_valid) state_nxt = cmd_wr_imm ? RESP : ISSUE;
         end
         ISSUE: begin
            done = (cnt == 4'd0);
            if (done) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // r0 is hard-wired to zero on the read side; its storage is never written
   assign rs1_val = (cmd_rs1 == 3'd0) ? '0 : rf[cmd_rs1];
   assign rs2_val = (cmd_rs2 == 3'd0) ? '0 : rf[cmd_rs2];

   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = cmd_rd;
      wr_data = cmd_imm;
      if (accept && cmd_wr_imm) begin
         wr_en = (cmd_rd != 3'd0);
      end else if (done) begin
         wr_en   = (rd_q != 3'd0);
         wr_idx  = rd_q;
         wr_data = alu_y;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) rf[i] <= '0;
      end else if (wr_en) begin
         rf[wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         alu_cin   <= 1'b0;
         rd_q      <= '0;
         cnt       <= '0;
         flags     <= '0;
         rsp_data  <= '0;
         rsp_flags <= '0;
      end else begin
         if (accept && cmd_wr_imm) begin
            rsp_data  <= cmd_imm;
            rsp_flags <= flags;
         end else if (accept) begin
            alu_a   <= rs1_val;
            alu_b   <= rs2_val;
            alu_sel <= cmd_sel;
            alu_cin <= cmd_use_carry & flags[3];
            rd_q    <= cmd_rd;
            cnt     <= CNT_LOAD;
         end
         if (state == ISSUE && !done) cnt <= cnt - 4'd1;
         if (done) begin
            flags     <= {alu_cout, alu_neg, alu_zero, alu_ovf};
            rsp_data  <= alu_y;
            rsp_flags <= {alu_cout, alu_neg, alu_zero, alu_ovf};
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 32-bit ALU attached.
// Expected results are hand-computed constants.
module tb_alu_cmd_sequencer;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [3:0]   cmd_sel;
   logic         cmd_wr_imm;
   logic         cmd_use_carry;
   logic [2:0]   cmd_rd;
   logic [2:0]   cmd_rs1;
   logic [2:0]   cmd_rs2;
   logic [W-1:0] cmd_imm;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [3:0]   alu_sel;
   logic         alu_cin;
   logic [W-1:0] alu_y;
   logic         alu_cout;
   logic         alu_neg;
   logic         alu_zero;
   logic         alu_ovf;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_data;
   logic [3:0]   rsp_flags;

   int n_vec = 0;
   int n_bad = 0;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0110;
   localparam logic [3:0] OP_SUB = 4'b0111;
   localparam logic [3:0] OP_RSV = 4'b1000;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.WIDTH(W), .ALU_LAT(1)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_sel       (cmd_sel),
      .cmd_wr_imm    (cmd_wr_imm),
      .cmd_use_carry (cmd_use_carry),
      .cmd_rd        (cmd_rd),
      .cmd_rs1       (cmd_rs1),
      .cmd_rs2       (cmd_rs2),
      .cmd_imm       (cmd_imm),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_sel       (alu_sel),
      .alu_cin       (alu_cin),
      .alu_y         (alu_y),
      .alu_cout      (alu_cout),
      .alu_neg       (alu_neg),
      .alu_zero      (alu_zero),
      .alu_ovf       (alu_ovf),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_flags     (rsp_flags)
   );

   // Behavioural ALU standing in for the real combinational unit
   logic [W:0] sum;
   always_comb begin
      sum      = '0;
      alu_y    = alu_a & alu_b;
      alu_cout = 1'b0;
      alu_ovf  = 1'b0;
      case (alu_sel)
         4'b0001: alu_y = alu_a | alu_b;
         4'b0010: alu_y = ~alu_a;
         4'b0011: alu_y = ~(alu_a | alu_b);
         4'b0100: alu_y = alu_a ^ alu_b;
         4'b0101: alu_y = ~(alu_a & alu_b);
         4'b0110: begin
            sum      = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
            alu_y    = sum[W-1:0];
            alu_cout = sum[W];
            alu_ovf  = (alu_a[W-1] == alu_b[W-1]) && (alu_y[W-1] != alu_a[W-1]);
         end
         4'b0111: begin
            sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + 1;
            alu_y    = sum[W-1:0];
            alu_cout = sum[W];
            alu_ovf  = (alu_a[W-1] != alu_b[W-1]) && (alu_y[W-1] != alu_a[W-1]);
         end
         default: alu_y = alu_a & alu_b;
      endcase
      alu_neg  = alu_y[W-1];
      alu_zero = (alu_y == '0);
   end

   task automatic chk(input string tag, input logic [W-1:0] got,
                      input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic imm_w, input logic [3:0] sel,
                       input logic uc, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [W-1:0] imm);
      int n;
      @(negedge clk);
      cmd_valid     = 1'b1;
      cmd_wr_imm    = imm_w;
      cmd_sel       = sel;
      cmd_use_carry = uc;
      cmd_rd        = rd;
      cmd_rs1       = rs1;
      cmd_rs2       = rs2;
      cmd_imm       = imm;
      n = 0;
      while (!cmd_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(output logic [W-1:0] data, output logic [3:0] fl,
                          output int cyc);
      rsp_ready = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!rsp_valid && cyc < 40);
      if (!rsp_valid) chk("rsp_timeout", 0, 1);
      data = rsp_data;
      fl   = rsp_flags;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input string tag, input logic imm_w,
                      input logic [3:0] sel, input logic uc,
                      input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic [W-1:0] imm,
                      input logic [W-1:0] exp_d, input logic [3:0] exp_f,
                      input int exp_lat);
      logic [W-1:0] d;
      logic [3:0]   f;
      int           cyc;
      send(imm_w, sel, uc, rd, rs1, rs2, imm);
      get_rsp(d, f, cyc);
      chk({tag, "_data"}, d, exp_d);
      chk({tag, "_flags"}, 32'(f), 32'(exp_f));
      chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
   endtask

   initial begin
      logic [W-1:0] held;
      int           n;
      rst_n         = 1'b0;
      cmd_valid     = 1'b0;
      cmd_sel       = '0;
      cmd_wr_imm    = 1'b0;
      cmd_use_carry = 1'b0;
      cmd_rd        = '0;
      cmd_rs1       = '0;
      cmd_rs2       = '0;
      cmd_imm       = '0;
      rsp_ready     = 1'b1;

      // reset
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 1);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_sel", 32'(alu_sel), 0);
      chk("rst_alu_cin", 32'(alu_cin), 0);
      chk("rst_rsp_flags", 32'(rsp_flags), 0);
      chk("rst_rsp_data", rsp_data, 0);
      run("or_rst", 0, OP_OR, 0, 3'd3, 3'd1, 3'd2, 0, 32'h0, 4'b0010, 2);

      // immediates then AND
      run("imm_r1", 1, 0, 0, 3'd1, 0, 0, 32'h0000_00FF, 32'h0000_00FF, 4'b0010, 1);
      run("imm_r2", 1, 0, 0, 3'd2, 0, 0, 32'h0000_0F0F, 32'h0000_0F0F, 4'b0010, 1);
      run("and", 0, OP_AND, 0, 3'd3, 3'd1, 3'd2, 0, 32'h0000_000F, 4'b0000, 2);

      // ADD signed overflow
      run("imm_r1b", 1, 0, 0, 3'd1, 0, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0000, 1);
      run("imm_r2b", 1, 0, 0, 3'd2, 0, 0, 32'h1, 32'h1, 4'b0000, 1);
      run("add_ovf", 0, OP_ADD, 0, 3'd4, 3'd1, 3'd2, 0, 32'h8000_0000, 4'b0101, 2);

      // carry chain
      run("imm_r1c", 1, 0, 0, 3'd1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0101, 1);
      run("add_carry", 0, OP_ADD, 0, 3'd4, 3'd1, 3'd2, 0, 32'h0, 4'b1010, 2);
      send(0, OP_ADD, 1, 3'd6, 3'd0, 3'd0, 0);
      chk("cin_set", 32'(alu_cin), 1);
      begin
         logic [W-1:0] d;
         logic [3:0]   f;
         int           cyc;
         get_rsp(d, f, cyc);
         chk("adc_data", d, 32'h1);
         chk("adc_flags", 32'(f), 0);
      end
      run("sub", 0, OP_SUB, 0, 3'd7, 3'd1, 3'd2, 0, 32'hFFFF_FFFE, 4'b1100, 2);
      send(0, OP_RSV, 0, 3'd7, 3'd1, 3'd2, 0);
      chk("rsv_sel", 32'(alu_sel), 32'h8);
      chk("rsv_cin", 32'(alu_cin), 0);
      begin
         logic [W-1:0] d;
         logic [3:0]   f;
         int           cyc;
         get_rsp(d, f, cyc);
         chk("rsv_data", d, 32'h1);
         chk("rsv_flags", 32'(f), 0);
      end
      run("rs_eq_rd", 0, OP_ADD, 0, 3'd7, 3'd7, 3'd7, 0, 32'h2, 4'b0000, 2);

      // backpressure: r1=FFFF_FFFF, r2=1, AND gives 1
      rsp_ready = 1'b0;
      send(0, OP_AND, 0, 3'd3, 3'd1, 3'd2, 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 40);
      chk("bp_valid", 32'(rsp_valid), 1);
      held = 32'h1;
      for (int i = 0; i < 5; i++) begin
         cmd_valid  = 1'b1;
         cmd_wr_imm = 1'b1;
         cmd_rd     = 3'd1;
         cmd_imm    = 32'hDEAD;
         @(negedge clk);
         chk("bp_data", rsp_data, held);
         chk("bp_ready", 32'(cmd_ready), 0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp_no_extra", 32'(rsp_valid), 0);
      run("bp_r1", 0, OP_OR, 0, 3'd0, 3'd1, 3'd1, 0, 32'hFFFF_FFFF, 4'b0100, 2);

      // r0 and reset abort
      run("imm_r0", 1, 0, 0, 3'd0, 0, 0, 32'h1234, 32'h1234, 4'b0100, 1);
      run("rd_r0", 0, OP_OR, 0, 3'd0, 3'd0, 3'd0, 0, 32'h0, 4'b0010, 2);
      run("imm_r1d", 1, 0, 0, 3'd1, 0, 0, 32'h5, 32'h5, 4'b0010, 1);
      send(0, OP_ADD, 0, 3'd5, 3'd1, 3'd1, 0);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("abort_ready", 32'(cmd_ready), 1);
      chk("abort_valid", 32'(rsp_valid), 0);
      chk("abort_flags", 32'(rsp_flags), 0);
      run("abort_r5", 0, OP_OR, 0, 3'd0, 3'd5, 3'd5, 0, 32'h0, 4'b0010, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
